iram_boot_loader: RTL and testbench

Serial boot loader sitting directly upstream of the instruction RAM write port (currently tied off). It receives a framed program image over the UART `rx` line, assembles 16-bit instruction words, and writes them sequentially into instruction RAM. It holds the CPU in reset until a complete image with a valid checksum has been stored.

---
 rtl/iram_boot_loader_pkg.sv | 8 +
 rtl/iram_boot_loader_if.sv | 9 +
 rtl/iram_boot_loader_uart_rx.sv | 49 ++++
 rtl/iram_boot_loader.sv | 102 ++++++++++
 tb/tb_iram_boot_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iram_boot_loader_pkg.sv
// iram_boot_loader_pkg: sync byte, loader FSM states and bit-period divisor shared by the boot loader
package iram_boot_loader_pkg;
  localparam logic [7:0] SYNC = 8'hA5;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE} state_t;
  function automatic int bit_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/iram_boot_loader_if.sv
// iram_boot_loader_if: serial input plus instruction RAM write port and CPU hold/status lines
interface iram_boot_loader_if #(parameter int ADDR_W = 12);
  logic rx;
  logic [ADDR_W-1:0] w_addr;
  logic [15:0] w_data;
  logic w_en, cpu_hold, load_done, load_error;
  modport master (input rx, output w_addr, w_data, w_en, cpu_hold, load_done, load_error);
  modport slave (output rx, input w_addr, w_data, w_en, cpu_hold, load_done, load_error);
endinterface

// File: rtl/iram_boot_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-FF synchroniser, mid-bit sampling and glitch/stop-bit rejection
module uart_rx import iram_boot_loader_pkg::*; #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD = 9600
) (
  input logic clk,
  input logic reset,
  input logic rx,
  output logic byte_valid,
  output logic [7:0] byte_data
);
  localparam int DIV = bit_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV);
  logic [2:0] sy;
  logic busy;
  logic [CW-1:0] cnt;
  logic [3:0] idx;
  // sy[1] is the synchronised line, sy[2] its previous value for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sy <= '1;
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      byte_valid <= 1'b0;
      byte_data <= '0;
    end else begin
      sy <= {sy[1:0], rx};
      byte_valid <= 1'b0;
      if (!busy) begin
        if (sy[2] && !sy[1]) begin
          busy <= 1'b1;
          cnt <= CW'(DIV / 2 - 1);
          idx <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= CW'(DIV - 1);
        idx <= idx + 1'b1;
        if (idx == 4'd0 && sy[1]) busy <= 1'b0;
        else if (idx == 4'd9) begin
          busy <= 1'b0;
          byte_valid <= sy[1];
        end else if (idx != 4'd0) byte_data <= {sy[1], byte_data[7:1]};
      end
    end
  end
endmodule

// File: rtl/iram_boot_loader.sv
// iram_boot_loader: parses framed UART images into instruction RAM and releases the CPU on a valid checksum
module iram_boot_loader import iram_boot_loader_pkg::*; #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD = 9600,
  parameter int ADDR_W = 12,
  parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
  input logic clk,
  input logic reset,
  iram_boot_loader_if.master bus
);
  localparam int MAX = 2 ** ADDR_W;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_n;
  logic byte_valid;
  logic [7:0] byte_data, len_lo, lo, csum;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] left;
  logic [TW-1:0] tmo;
  logic [16:0] n;
  logic w_en, load_done, load_error, expire, wr, err, done, sync;
  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk(clk), .reset(reset), .rx(bus.rx), .byte_valid(byte_valid), .byte_data(byte_data)
  );
  assign n = {1'b0, byte_data, len_lo};
  assign expire = state != IDLE && state != DONE && tmo == TW'(TIMEOUT_CYC - 1);
  assign bus.w_addr = addr;
  assign bus.w_en = w_en;
  assign bus.load_done = load_done;
  assign bus.load_error = load_error;
  assign bus.cpu_hold = !load_done;
  // a received byte always takes priority over a timeout expiring in the same cycle
  always_comb begin
    state_n = state;
    wr = 1'b0;
    err = 1'b0;
    done = 1'b0;
    sync = 1'b0;
    if (byte_valid)
      case (state)
        IDLE: begin
          sync = byte_data == SYNC;
          state_n = sync ? LEN_LO : IDLE;
        end
        LEN_LO: state_n = LEN_HI;
        LEN_HI: begin
          err = n == '0 || n > 17'(MAX);
          state_n = err ? IDLE : DATA_LO;
        end
        DATA_LO: state_n = DATA_HI;
        DATA_HI: begin
          wr = 1'b1;
          state_n = left == (ADDR_W + 1)'(1) ? CSUM : DATA_LO;
        end
        CSUM: begin
          done = byte_data == csum;
          err = !done;
          state_n = done ? DONE : IDLE;
        end
        default: ;
      endcase
    else if (expire) begin
      err = 1'b1;
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      left <= '0;
      len_lo <= '0;
      lo <= '0;
      csum <= '0;
      tmo <= '0;
      w_en <= 1'b0;
      bus.w_data <= '0;
      load_done <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state <= state_n;
      w_en <= wr;
      tmo <= (byte_valid || state_n == IDLE || state_n == DONE) ? '0 : tmo + 1'b1;
      if (wr) begin
        bus.w_data <= {byte_data, lo};
        left <= left - 1'b1;
      end
      if (w_en) addr <= addr + 1'b1;
      if (byte_valid && state == LEN_LO) len_lo <= byte_data;
      if (byte_valid && state == LEN_HI) left <= n[ADDR_W:0];
      if (byte_valid && state == DATA_LO) lo <= byte_data;
      if (byte_valid && (state == DATA_LO || state == DATA_HI)) csum <= csum + byte_data;
      if (sync) begin
        addr <= '0;
        csum <= '0;
        load_error <= 1'b0;
      end
      if (err) load_error <= 1'b1;
      if (done) load_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_iram_boot_loader.sv
// tb_iram_boot_loader: randomized frame-level checks of the boot loader against a word-list model
module tb_iram_boot_loader;
  localparam int CLK_HZ = 8, BAUD = 1, AW = 4, TMO = 300;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_bad = 0;
  logic [AW+15:0] wq[$], eq[$];
  logic [7:0] fr[$];
  logic [15:0] wd[$];
  logic [AW+19:0] outs;
  logic [2:0] flags;
  iram_boot_loader_if #(.ADDR_W(AW)) bus();
  iram_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  assign outs = {bus.cpu_hold, bus.w_en, bus.w_addr, bus.w_data, bus.load_done, bus.load_error};
  assign flags = {bus.load_done, bus.cpu_hold, bus.load_error};
  always @(negedge clk) if (bus.w_en) wq.push_back({bus.w_addr, bus.w_data});

  task automatic do_reset;
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) bus.rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (8) @(negedge clk);
    end
    bus.rx = stop;
    repeat (8) @(negedge clk);
    bus.rx = 1'b1;
    repeat ($urandom_range(3, 12)) @(negedge clk);
  endtask

  task automatic send_frame(input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(fr[i], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  // Model: a frame carries the words of wd; writes land at 0.. only when the length is legal
  task automatic build(input int len, input logic [7:0] csum_xor);
    logic [7:0] s;
    s = 8'h00;
    fr = {8'hA5, 8'(len), 8'(len >> 8)};
    eq.delete();
    foreach (wd[i]) begin
      fr.push_back(wd[i][7:0]);
      fr.push_back(wd[i][15:8]);
      s = s + wd[i][7:0] + wd[i][15:8];
    end
    fr.push_back(s ^ csum_xor);
    if (len >= 1 && len <= 2 ** AW) foreach (wd[i]) if (i < len) eq.push_back({AW'(i), wd[i]});
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if (outs !== {1'b1, (AW + 19)'(0)}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b", outs, {1'b1, (AW + 19)'(0)});
    end
  endtask

  task automatic test_good_frame;
    do_reset();
    wd = {16'h1234, 16'hABCD};
    build(2, 8'h00);
    send_frame(0, fr.size() - 1);
    n_cmp++;
    if (flags !== 3'b010) begin n_bad++; $display("FAIL good_before_csum: flags %b want 010", flags); end
    send_frame(fr.size() - 1, fr.size());
    n_cmp++;
    if (wq.size() != eq.size()) begin n_bad++; $display("FAIL good_writes: count %0d want %0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin n_bad++; $display("FAIL good_write%0d: got %h want %h", i, wq[i], eq[i]); end
    end
    n_cmp++;
    if (flags !== 3'b100) begin n_bad++; $display("FAIL good_flags: got %b want 100", flags); end
  endtask

  task automatic test_bad_csum;
    do_reset();
    wd = {16'h1234, 16'hABCD};
    build(2, 8'h00);
    fr[fr.size() - 1] = 8'h13;
    send_frame(0, fr.size());
    n_cmp++;
    if (wq.size() != 2) begin n_bad++; $display("FAIL badcs_writes: count %0d want 2", wq.size()); end
    n_cmp++;
    if (flags !== 3'b011) begin n_bad++; $display("FAIL badcs_flags: got %b want 011", flags); end
    wq.delete();
    build(2, 8'h00);
    send_frame(0, fr.size());
    n_cmp++;
    if (wq.size() != eq.size()) begin n_bad++; $display("FAIL resend_writes: count %0d want %0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin n_bad++; $display("FAIL resend_write%0d: got %h want %h", i, wq[i], eq[i]); end
    end
    n_cmp++;
    if (flags !== 3'b100) begin n_bad++; $display("FAIL resend_flags: got %b want 100", flags); end
  endtask

  task automatic test_len_bounds;
    do_reset();
    wd.delete();
    build(0, 8'h00);
    send_frame(0, fr.size());
    n_cmp++;
    if ({wq.size() == 0, flags} !== 4'b1011) begin n_bad++; $display("FAIL len0: writes %0d flags %b want 0/011", wq.size(), flags); end
    build(2 ** AW + 1, 8'h00);
    send_frame(0, fr.size());
    n_cmp++;
    if ({wq.size() == 0, flags} !== 4'b1011) begin n_bad++; $display("FAIL len_over: writes %0d flags %b want 0/011", wq.size(), flags); end
    for (int i = 0; i < 2 ** AW; i++) wd.push_back(16'($urandom));
    build(2 ** AW, 8'h00);
    send_frame(0, fr.size());
    n_cmp++;
    if (wq.size() != eq.size()) begin n_bad++; $display("FAIL len_max_writes: count %0d want %0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin n_bad++; $display("FAIL len_max_write%0d: got %h want %h", i, wq[i], eq[i]); end
    end
    n_cmp++;
    if ({bus.w_addr, flags} !== {AW'(0), 3'b100}) begin n_bad++; $display("FAIL len_max_end: addr %0d flags %b want 0/100", bus.w_addr, flags); end
  endtask

  task automatic test_garbage;
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    wd = {16'($urandom), 16'($urandom), 16'($urandom)};
    build(3, 8'h00);
    send_frame(0, fr.size());
    n_cmp++;
    if (wq.size() != eq.size()) begin n_bad++; $display("FAIL garbage_writes: count %0d want %0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin n_bad++; $display("FAIL garbage_write%0d: got %h want %h", i, wq[i], eq[i]); end
    end
    n_cmp++;
    if (flags !== 3'b100) begin n_bad++; $display("FAIL garbage_flags: got %b want 100", flags); end
  endtask

  task automatic test_bad_stop;
    do_reset();
    wd = {16'h1234};
    build(1, 8'h00);
    send_frame(0, 4);
    send_byte(fr[4], 1'b0);
    n_cmp++;
    if (flags !== 3'b010) begin n_bad++; $display("FAIL badstop_early: flags %b want 010", flags); end
    repeat (TMO + 50) @(negedge clk);
    n_cmp++;
    if ({wq.size() == 0, flags} !== 4'b1011) begin n_bad++; $display("FAIL badstop_timeout: writes %0d flags %b want 0/011", wq.size(), flags); end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5, 1'b1);
    n_cmp++;
    if (bus.load_error !== 1'b0) begin n_bad++; $display("FAIL sync_clears_error: got %b want 0", bus.load_error); end
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (TMO - 50) @(negedge clk);
    n_cmp++;
    if (bus.load_error !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", bus.load_error); end
    repeat (100) @(negedge clk);
    n_cmp++;
    if (flags !== 3'b011) begin n_bad++; $display("FAIL timeout_flags: got %b want 011", flags); end
    wd = {16'hBEEF};
    build(1, 8'h00);
    wq.delete();
    send_frame(0, fr.size());
    n_cmp++;
    if ({wq.size() == 1, flags} !== 4'b1100) begin n_bad++; $display("FAIL timeout_recover: writes %0d flags %b want 1/100", wq.size(), flags); end
  endtask

  task automatic test_after_done;
    wq.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'hBB, 1'b1);
    n_cmp++;
    if ({wq.size() == 0, flags} !== 4'b1100) begin n_bad++; $display("FAIL after_done: writes %0d flags %b want 0/100", wq.size(), flags); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    wd = {16'h1234, 16'hABCD};
    build(2, 8'h00);
    send_frame(0, 6);
    do_reset();
    n_cmp++;
    if (outs !== {1'b1, (AW + 19)'(0)}) begin n_bad++; $display("FAIL midreset_outputs: got %b want %b", outs, {1'b1, (AW + 19)'(0)}); end
    send_frame(6, fr.size());
    n_cmp++;
    if ({wq.size() == 0, flags} !== 4'b1010) begin n_bad++; $display("FAIL midreset_nowrite: writes %0d flags %b want 0/010", wq.size(), flags); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      int len;
      logic [7:0] cx;
      do_reset();
      len = $urandom_range(1, 2 ** AW);
      cx = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      wd.delete();
      for (int i = 0; i < len; i++) wd.push_back(16'($urandom));
      build(len, cx);
      send_frame(0, fr.size());
      n_cmp++;
      if (wq.size() != eq.size()) begin n_bad++; $display("FAIL rand%0d_writes: count %0d want %0d", k, wq.size(), eq.size()); end
      else foreach (eq[i]) begin
        n_cmp++;
        if (wq[i] !== eq[i]) begin n_bad++; $display("FAIL rand%0d_write%0d: got %h want %h", k, i, wq[i], eq[i]); end
      end
      n_cmp++;
      if (flags !== (cx == 8'h00 ? 3'b100 : 3'b011)) begin
        n_bad++;
        $display("FAIL rand%0d_flags: got %b want %b", k, flags, cx == 8'h00 ? 3'b100 : 3'b011);
      end
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_bounds();
    test_garbage();
    test_bad_stop();
    test_timeout();
    test_after_done();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
